mc_control_unit: RTL and testbench

//  Next-generation multicycle control unit for the ARM-subset core: instruction

---
 rtl/mc_control_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle ARM-subset control unit: main FSM, decoder, multiply stall, memory handshake
// Optional FPU execute state is built only when MC_CONTROL_FPU_EN is defined.
module mc_control_unit #(
    parameter int MUL_LAT   = 4,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Mul,
    input  logic                 MemReady,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 FPUW,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Busy,
    output logic                 Undef
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_MULEX,
        S_ALUWB,
        S_BRANCH,
        S_FPUEX
    } state_t;

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state;
    logic [3:0] mul_cnt;

    logic       is_mul;
    logic       alu_ok;
    logic       undef_enc;
    logic [2:0] alu_dec;

    logic       irwrite_s;
    logic       nextpc_s;
    logic       regw_s;
    logic       memw_s;
    logic       adrsrc_s;
    logic       branch_s;
    logic       aluop_s;
    logic       busy_s;
    logic       undef_s;
    logic       flag_en;
    logic [1:0] rs_s;
    logic [1:0] as_s;
    logic [1:0] bs_s;
    logic [1:0] flagw_s;
`ifdef MC_CONTROL_FPU_EN
    logic       fpuw_s;
`endif

    // Instruction-field decode; the IR is stable from DECODE onward, so this is valid wherever it is used.
    always_comb begin
        is_mul  = ~Funct[5] & (Mul == 4'b1001);
        alu_dec = 3'b000;
        alu_ok  = 1'b1;
        if (is_mul) begin
            case (Funct[4:1])
                4'b0000: alu_dec = 3'b101;
                4'b0100: alu_dec = 3'b110;
                4'b0110: alu_dec = 3'b111;
                default: alu_ok  = 1'b0;
            endcase
        end else begin
            case (Funct[4:1])
                4'b0100: alu_dec = 3'b000;
                4'b0010: alu_dec = 3'b001;
                4'b0000: alu_dec = 3'b010;
                4'b1100: alu_dec = 3'b011;
                4'b0001: alu_dec = 3'b100;
                default: alu_ok  = 1'b0;
            endcase
        end
    end

    always_comb begin
        undef_enc = 1'b0;
        case (Op)
            2'b00:   undef_enc = ~alu_ok;
`ifdef MC_CONTROL_FPU_EN
            2'b11:   undef_enc = 1'b0;
`else
            2'b11:   undef_enc = 1'b1;
`endif
            default: undef_enc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_FETCH;
            mul_cnt <= 4'd0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (undef_enc) begin
                        state <= S_FETCH;
                    end else begin
                        case (Op)
                            2'b00: begin
                                if (Funct[5]) begin
                                    state <= S_EXECI;
                                end else if (is_mul) begin
                                    state   <= S_MULEX;
                                    mul_cnt <= MUL_CNT_INIT;
                                end else begin
                                    state <= S_EXECR;
                                end
                            end
                            2'b01:   state <= S_MEMADR;
                            2'b10:   state <= S_BRANCH;
`ifdef MC_CONTROL_FPU_EN
                            default: state <= S_FPUEX;
`else
                            default: state <= S_FETCH;
`endif
                        endcase
                    end
                end
                S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (MemReady) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (MemReady) state <= S_FETCH;
                end
                S_EXECR, S_EXECI: state <= S_ALUWB;
                S_MULEX: begin
                    if (mul_cnt == 4'd0) state <= S_ALUWB;
                    else                 mul_cnt <= mul_cnt - 4'd1;
                end
`ifdef MC_CONTROL_FPU_EN
                S_FPUEX: state <= S_ALUWB;
`endif
                // ALUWB, MEMWB and BRANCH all retire to FETCH.
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        irwrite_s = 1'b0;
        nextpc_s  = 1'b0;
        regw_s    = 1'b0;
        memw_s    = 1'b0;
        adrsrc_s  = 1'b0;
        branch_s  = 1'b0;
        aluop_s   = 1'b0;
        busy_s    = 1'b0;
        undef_s   = 1'b0;
        rs_s      = 2'b00;
        as_s      = 2'b00;
        bs_s      = 2'b00;
`ifdef MC_CONTROL_FPU_EN
        fpuw_s    = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                irwrite_s = 1'b1;
                nextpc_s  = 1'b1;
                as_s      = 2'b01;
                bs_s      = 2'b10;
                rs_s      = 2'b10;
            end
            S_DECODE: begin
                as_s    = 2'b01;
                bs_s    = 2'b10;
                rs_s    = 2'b10;
                undef_s = undef_enc;
            end
            S_MEMADR: bs_s = 2'b01;
            S_MEMRD: begin
                adrsrc_s = 1'b1;
                busy_s   = ~MemReady;
            end
            S_MEMWB: begin
                rs_s   = 2'b01;
                regw_s = 1'b1;
            end
            S_MEMWR: begin
                adrsrc_s = 1'b1;
                memw_s   = 1'b1;
                busy_s   = ~MemReady;
            end
            S_EXECR: aluop_s = 1'b1;
            S_EXECI: begin
                bs_s    = 2'b01;
                aluop_s = 1'b1;
            end
            S_MULEX: begin
                aluop_s = 1'b1;
                busy_s  = 1'b1;
            end
            S_ALUWB: regw_s = 1'b1;
            S_BRANCH: begin
                as_s     = 2'b10;
                bs_s     = 2'b01;
                rs_s     = 2'b10;
                branch_s = 1'b1;
            end
`ifdef MC_CONTROL_FPU_EN
            S_FPUEX: fpuw_s = 1'b1;
`endif
            default: ;
        endcase
    end

    // A multiply updates flags only once, on its last MULEX cycle.
    assign flag_en = aluop_s & ((state != S_MULEX) | (mul_cnt == 4'd0));
    assign flagw_s = flag_en ? {Funct[0], Funct[0] & (alu_dec[2:1] == 2'b00)} : 2'b00;

    // Every output is forced low while reset is held.
    assign IRWrite    = reset & irwrite_s;
    assign NextPC     = reset & nextpc_s;
    assign RegW       = reset & regw_s;
    assign MemW       = reset & memw_s;
    assign AdrSrc     = reset & adrsrc_s;
    assign Busy       = reset & busy_s;
    assign Undef      = reset & undef_s;
    assign PCS        = reset & (((Rd == 4'hF) & regw_s) | branch_s);
    assign FlagW      = reset ? flagw_s : 2'b00;
    assign ResultSrc  = reset ? rs_s : 2'b00;
    assign ALUSrcA    = reset ? as_s : 2'b00;
    assign ALUSrcB    = reset ? bs_s : 2'b00;
    assign ImmSrc     = reset ? Op : 2'b00;
    assign RegSrc     = reset ? {Op == 2'b01, Op == 2'b10} : 2'b00;
    assign ALUControl = (reset & aluop_s) ? ALUCTRL_W'(alu_dec) : '0;
`ifdef MC_CONTROL_FPU_EN
    assign FPUW       = reset & fpuw_s;
`else
    assign FPUW       = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - bench for mc_control_unit: per-cycle scoreboard from an instruction-level model
module tb_mc_control_unit;

    typedef struct packed {
        logic [1:0] flagw;
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       irwrite;
        logic       adrsrc;
        logic       fpuw;
        logic [1:0] rs;
        logic [1:0] as;
        logic [1:0] bs;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [3:0] alu;
        logic       busy;
        logic       undef;
    } rec_t;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } lit_t;

`ifdef MC_CONTROL_FPU_EN
    localparam bit FPU = 1'b1;
`else
    localparam bit FPU = 1'b0;
`endif
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd, Mul;
    logic       MemReady;

    logic [1:0] FlagW_a, ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a, RegSrc_a;
    logic       PCS_a, NextPC_a, RegW_a, MemW_a, IRWrite_a, AdrSrc_a, FPUW_a, Busy_a, Undef_a;
    logic [2:0] ALUControl_a;
    logic [1:0] FlagW_b, ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, RegSrc_b;
    logic       PCS_b, NextPC_b, RegW_b, MemW_b, IRWrite_b, AdrSrc_b, FPUW_b, Busy_b, Undef_b;
    logic [3:0] ALUControl_b;

    rec_t got_a, got_b, ea, eb, zero_r;
    rec_t bq[$];
    bit   bm[$];
    rec_t exp_a[$], exp_b[$];
    lit_t lit_q[$];
    lit_t lq;

    int checks = 0;
    int errors = 0;
    int n_busy_a = 0, n_busy_b = 0, n_pcs_a = 0, n_undef_a = 0, n_regw_a = 0, n_memw_a = 0, n_fpuw_a = 0;
    int s0, s1;

    always #5 clk = ~clk;

    mc_control_unit #(.MUL_LAT(LAT_A), .ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset_a), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul), .MemReady(MemReady),
        .FlagW(FlagW_a), .PCS(PCS_a), .NextPC(NextPC_a), .RegW(RegW_a), .MemW(MemW_a),
        .IRWrite(IRWrite_a), .AdrSrc(AdrSrc_a), .FPUW(FPUW_a), .ResultSrc(ResultSrc_a),
        .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .ImmSrc(ImmSrc_a), .RegSrc(RegSrc_a),
        .ALUControl(ALUControl_a), .Busy(Busy_a), .Undef(Undef_a)
    );

    mc_control_unit #(.MUL_LAT(LAT_B), .ALUCTRL_W(4)) dut_b (
        .clk(clk), .reset(reset_b), .Op(Op), .Funct(Funct), .Rd(Rd), .Mul(Mul), .MemReady(MemReady),
        .FlagW(FlagW_b), .PCS(PCS_b), .NextPC(NextPC_b), .RegW(RegW_b), .MemW(MemW_b),
        .IRWrite(IRWrite_b), .AdrSrc(AdrSrc_b), .FPUW(FPUW_b), .ResultSrc(ResultSrc_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .RegSrc(RegSrc_b),
        .ALUControl(ALUControl_b), .Busy(Busy_b), .Undef(Undef_b)
    );

    assign got_a = {FlagW_a, PCS_a, NextPC_a, RegW_a, MemW_a, IRWrite_a, AdrSrc_a, FPUW_a, ResultSrc_a,
                    ALUSrcA_a, ALUSrcB_a, ImmSrc_a, RegSrc_a, 1'b0, ALUControl_a, Busy_a, Undef_a};
    assign got_b = {FlagW_b, PCS_b, NextPC_b, RegW_b, MemW_b, IRWrite_b, AdrSrc_b, FPUW_b, ResultSrc_b,
                    ALUSrcA_b, ALUSrcB_b, ImmSrc_b, RegSrc_b, ALUControl_b, Busy_b, Undef_b};
    assign zero_r = '0;

    function automatic rec_t base(input logic [1:0] op);
        rec_t r = '0;
        r.imm    = op;
        r.regsrc = {op == 2'b01, op == 2'b10};
        return r;
    endfunction

    function automatic void put(input rec_t r, input bit mr);
        bq.push_back(r);
        bm.push_back(mr);
    endfunction

    // Expected per-cycle outputs of one whole instruction, and the MemReady to drive with each cycle.
    function automatic void build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                                  input logic [3:0] mul, input int lat, input int waits);
        rec_t       b, r;
        int         code;
        bit         ismul, und;
        logic [1:0] fw;
        bq.delete();
        bm.delete();
        b     = base(op);
        ismul = (op == 2'b00) && !f[5] && (mul == 4'b1001);
        code  = -1;
        if (op == 2'b00) begin
            if (ismul) begin
                case (f[4:1])
                    4'b0000: code = 5;
                    4'b0100: code = 6;
                    4'b0110: code = 7;
                    default: code = -1;
                endcase
            end else begin
                case (f[4:1])
                    4'b0100: code = 0;
                    4'b0010: code = 1;
                    4'b0000: code = 2;
                    4'b1100: code = 3;
                    4'b0001: code = 4;
                    default: code = -1;
                endcase
            end
        end
        und = ((op == 2'b00) && (code < 0)) || ((op == 2'b11) && !FPU);
        fw  = {f[0], f[0] & (code >= 0 && code < 2)};
        r = b; r.irwrite = 1; r.nextpc = 1; r.as = 2'b01; r.bs = 2'b10; r.rs = 2'b10;
        put(r, bit'($urandom_range(0, 1)));
        r = b; r.as = 2'b01; r.bs = 2'b10; r.rs = 2'b10; r.undef = und;
        put(r, bit'($urandom_range(0, 1)));
        if (und) return;
        case (op)
            2'b00: begin
                if (ismul) begin
                    for (int i = 0; i < lat; i++) begin
                        r = b; r.alu = 4'(code); r.busy = 1; r.flagw = (i == lat - 1) ? fw : 2'b00;
                        put(r, bit'($urandom_range(0, 1)));
                    end
                end else begin
                    r = b; r.bs = f[5] ? 2'b01 : 2'b00; r.alu = 4'(code); r.flagw = fw;
                    put(r, bit'($urandom_range(0, 1)));
                end
                r = b; r.regw = 1; r.pcs = (rd == 4'hF);
                put(r, bit'($urandom_range(0, 1)));
            end
            2'b01: begin
                r = b; r.bs = 2'b01;
                put(r, bit'($urandom_range(0, 1)));
                for (int i = 0; i <= waits; i++) begin
                    r = b; r.adrsrc = 1; r.memw = !f[0]; r.busy = (i < waits);
                    put(r, i == waits);
                end
                if (f[0]) begin
                    r = b; r.rs = 2'b01; r.regw = 1; r.pcs = (rd == 4'hF);
                    put(r, bit'($urandom_range(0, 1)));
                end
            end
            2'b10: begin
                r = b; r.as = 2'b10; r.bs = 2'b01; r.rs = 2'b10; r.pcs = 1;
                put(r, bit'($urandom_range(0, 1)));
            end
            default: begin
                r = b; r.fpuw = 1;
                put(r, bit'($urandom_range(0, 1)));
                r = b; r.regw = 1; r.pcs = (rd == 4'hF);
                put(r, bit'($urandom_range(0, 1)));
            end
        endcase
    endfunction

    task automatic pin(input string name, input int got, input int exp);
        lit_t l;
        l.name = name;
        l.got  = got;
        l.exp  = exp;
        lit_q.push_back(l);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            reset_a  = 1'b0;
            reset_b  = 1'b0;
            Op       = 2'($urandom);
            Funct    = 6'($urandom);
            Rd       = 4'($urandom);
            Mul      = 4'($urandom);
            MemReady = 1'($urandom);
            exp_a.push_back(zero_r);
            exp_b.push_back(zero_r);
        end
        settle();
    endtask

    // who selects the active instance; the other is held in reset and must stay all-zero.
    task automatic run(input int who, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                       input logic [3:0] mul, input int waits, input int cut);
        int n;
        build(op, f, rd, mul, (who == 0) ? LAT_A : LAT_B, waits);
        n = (cut >= 0 && cut < bq.size()) ? cut : bq.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            reset_a  = (who == 0);
            reset_b  = (who == 1);
            Op       = op;
            Funct    = f;
            Rd       = rd;
            Mul      = mul;
            MemReady = bm[k];
            exp_a.push_back((who == 0) ? bq[k] : zero_r);
            exp_b.push_back((who == 1) ? bq[k] : zero_r);
        end
        settle();
    endtask

    always @(negedge clk) begin
        if (exp_a.size() > 0) begin
            ea = exp_a.pop_front();
            checks++;
            if (got_a !== ea) begin
                errors++;
                $display("FAIL cycle_a t=%0t got=%h exp=%h", $time, got_a, ea);
            end
            if (got_a.busy)  n_busy_a++;
            if (got_a.pcs)   n_pcs_a++;
            if (got_a.undef) n_undef_a++;
            if (got_a.regw)  n_regw_a++;
            if (got_a.memw)  n_memw_a++;
            if (got_a.fpuw)  n_fpuw_a++;
        end
        if (exp_b.size() > 0) begin
            eb = exp_b.pop_front();
            checks++;
            if (got_b !== eb) begin
                errors++;
                $display("FAIL cycle_b t=%0t got=%h exp=%h", $time, got_b, eb);
            end
            if (got_b.busy) n_busy_b++;
        end
        while (lit_q.size() > 0) begin
            lq = lit_q.pop_front();
            checks++;
            if (lq.got != lq.exp) begin
                errors++;
                $display("FAIL %s got=%0d exp=%0d", lq.name, lq.got, lq.exp);
            end
        end
    end

    initial begin
        reset_a = 0; reset_b = 0; Op = 0; Funct = 0; Rd = 0; Mul = 0; MemReady = 0;
        rst_cycles(3);

        run(0, 2'b00, 6'b001001, 4'd1, 4'b0000, 0, -1);
        pin("fetch_irw_nextpc", int'(bq[0].irwrite & bq[0].nextpc), 1);
        pin("adds_len", bq.size(), 4);
        pin("adds_alu", int'(bq[2].alu), 0);
        pin("adds_flagw", int'(bq[2].flagw), 3);
        pin("adds_regw_pcs", int'({bq[3].regw, bq[3].pcs}), 2);

        s0 = n_busy_a;
        run(0, 2'b00, 6'b000000, 4'd2, 4'b1001, 0, -1);
        pin("mul4_len", bq.size(), 7);
        pin("mul4_alu", int'(bq[2].alu), 5);
        pin("mul4_busy", n_busy_a - s0, 4);

        s0 = n_busy_b;
        run(1, 2'b00, 6'b000000, 4'd2, 4'b1001, 0, -1);
        pin("mul1_busy", n_busy_b - s0, 1);
        run(1, 2'b00, 6'b001100, 4'd3, 4'b1001, 0, -1);
        pin("umul_alu", int'(bq[2].alu), 7);

        run(0, 2'b00, 6'b001001, 4'd4, 4'b1001, 0, -1);
        pin("smuls_flagw_last", int'(bq[5].flagw), 2);

        s0 = n_busy_a; s1 = n_regw_a;
        run(0, 2'b01, 6'b011001, 4'd3, 4'b0000, 3, -1);
        pin("ldr_len", bq.size(), 8);
        pin("ldr_busy", n_busy_a - s0, 3);
        pin("ldr_regw", n_regw_a - s1, 1);

        s0 = n_memw_a;
        run(0, 2'b01, 6'b011000, 4'd5, 4'b0000, 2, -1);
        pin("str_memw", n_memw_a - s0, 3);

        s0 = n_pcs_a;
        run(0, 2'b00, 6'b111000, 4'hF, 4'b0000, 0, -1);
        pin("orr_r15_pcs", n_pcs_a - s0, 1);
        run(0, 2'b00, 6'b100101, 4'd6, 4'b1001, 0, -1);
        pin("subsi_flagw", int'(bq[2].flagw), 3);
        run(0, 2'b00, 6'b000010, 4'd7, 4'b0000, 0, -1);
        run(0, 2'b00, 6'b000000, 4'd8, 4'b0000, 0, -1);

        s0 = n_pcs_a;
        run(0, 2'b10, 6'b100000, 4'd0, 4'b0000, 0, -1);
        pin("branch_pcs", n_pcs_a - s0, 1);

        s0 = n_undef_a; s1 = n_regw_a;
        run(0, 2'b00, 6'b011110, 4'd1, 4'b0000, 0, -1);
        pin("undef_pulse", n_undef_a - s0, 1);
        pin("undef_regw", n_regw_a - s1, 0);
        run(0, 2'b00, 6'b000010, 4'd1, 4'b1001, 0, -1);

        s0 = n_undef_a; s1 = n_fpuw_a;
        run(0, 2'b11, 6'b000000, 4'd2, 4'b0000, 0, -1);
        pin("op11_undef", n_undef_a - s0, FPU ? 0 : 1);
        pin("op11_fpuw", n_fpuw_a - s1, FPU ? 1 : 0);

        run(0, 2'b00, 6'b000000, 4'd2, 4'b1001, 0, 4);
        rst_cycles(2);
        run(0, 2'b00, 6'b001001, 4'd1, 4'b0000, 0, -1);

        for (int i = 0; i < 30; i++) begin
            run(0, 2'($urandom), 6'($urandom), 4'($urandom),
                ($urandom_range(0, 2) == 0) ? 4'b1001 : 4'($urandom), $urandom_range(0, 3), -1);
        end

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
